// File: rtl/demux2_4_stream.sv
// demux2_4_stream: 1-to-2 valid/ready stream demultiplexer.
// Each input word carries a select bit and is steered into one of two small
// output FIFOs, so a stalled consumer only blocks words addressed to it.
// A delivered-word counter is kept for each output.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake; in_ready reflects FIFO[in_sel]
//   in_data, in_sel         input word and destination (0 -> out0, 1 -> out1)
//   outN_valid/outN_ready   output N handshake
//   outN_data               head of output FIFO N, 0 when empty
//   cnt0, cnt1              words delivered on each output (wrapping)
module demux2_4_stream #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q    [2][DEPTH];
    logic [PW-1:0]    wr_ptr_q [2];
    logic [PW-1:0]    rd_ptr_q [2];
    logic [OW-1:0]    occ_q    [2];
    logic [OW-1:0]    occ_d    [2];
    logic [CNT_W-1:0] cnt_q    [2];

    logic [1:0] full;
    logic [1:0] valid;
    logic [1:0] ready;
    logic [1:0] push;
    logic [1:0] pop;
    logic       accept;

    // Full/empty come from occupancy; pointers alone cannot tell them apart.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full[i]  = (occ_q[i] == OW'(DEPTH));
            valid[i] = (occ_q[i] != '0);
        end
    end

    assign ready = {out1_ready, out0_ready};

    // Gated by rst_n so the block never advertises readiness while in reset.
    assign in_ready = rst_n & ~(in_sel ? full[1] : full[0]);
    assign accept   = in_valid & in_ready;
    assign push     = {accept & in_sel, accept & ~in_sel};
    assign pop      = valid & ready;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            occ_d[i] = occ_q[i];
            if (push[i] && !pop[i]) begin
                occ_d[i] = occ_q[i] + OW'(1);
            end else if (!push[i] && pop[i]) begin
                occ_d[i] = occ_q[i] - OW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem_q[i][wr_ptr_q[i]] <= in_data;
                    wr_ptr_q[i]           <= wr_ptr_q[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
                    cnt_q[i]    <= cnt_q[i] + CNT_W'(1);
                end
                occ_q[i] <= occ_d[i];
            end
        end
    end

    assign out0_valid = valid[0];
    assign out1_valid = valid[1];
    assign out0_data  = valid[0] ? mem_q[0][rd_ptr_q[0]] : '0;
    assign out1_data  = valid[1] ? mem_q[1][rd_ptr_q[1]] : '0;
    assign cnt0       = cnt_q[0];
    assign cnt1       = cnt_q[1];

endmodule

// File: tb/tb_demux2_4_stream.sv
// Directed bench for demux2_4_stream with hand-computed expectations.
module tb_demux2_4_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_sel;
    logic       out0_valid;
    logic       out0_ready;
    logic [3:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [3:0] out1_data;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int passed = 0;
    int total  = 0;

    demux2_4_stream #(
        .WIDTH(4),
        .DEPTH(2),
        .CNT_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out0_data (out0_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .out1_data (out1_data),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; outputs are then settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [3:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = 4'h0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // Reset held for two cycles
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_v0", out0_valid, 0);
        check("rst_v1", out1_valid, 0);
        check("rst_d0", out0_data, 0);
        check("rst_d1", out1_data, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Routing
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1, 0, 4'd8);
        check("rt_rdy", in_ready, 1);
        tick();
        check("rt_v0_a", out0_valid, 1);
        check("rt_d0_a", out0_data, 8);
        drive(1, 0, 4'd7);
        tick();
        check("rt_d0_b", out0_data, 7);
        check("rt_cnt0_a", cnt0, 1);
        drive(1, 1, 4'd6);
        tick();
        check("rt_v0_empty", out0_valid, 0);
        check("rt_d0_zero", out0_data, 0);
        check("rt_d1_a", out1_data, 6);
        drive(1, 1, 4'd5);
        tick();
        check("rt_d1_b", out1_data, 5);
        drive(0, 0, 4'd0);
        tick();
        check("rt_v1_empty", out1_valid, 0);
        check("rt_cnt0", cnt0, 2);
        check("rt_cnt1", cnt1, 2);

        // Backpressure on out0
        out0_ready = 1'b0;
        drive(1, 0, 4'd4);
        tick();
        drive(1, 0, 4'd3);
        check("bp_rdy_3", in_ready, 1);
        tick();
        drive(1, 0, 4'd2);
        check("bp_rdy_2_blocked", in_ready, 0);
        tick();
        check("bp_head", out0_data, 4);
        check("bp_cnt0_hold", cnt0, 2);
        drive(1, 1, 4'd2);
        check("bp_rdy_sel1", in_ready, 1);
        tick();
        check("bp_v1", out1_valid, 1);
        check("bp_d1", out1_data, 2);
        drive(0, 0, 4'd0);
        tick();
        check("bp_cnt1", cnt1, 3);
        out0_ready = 1'b1;
        check("bp_d0_4", out0_data, 4);
        tick();
        check("bp_d0_3", out0_data, 3);
        tick();
        check("bp_v0_done", out0_valid, 0);
        check("bp_cnt0", cnt0, 4);

        // Full FIFO with simultaneous pop: no bypass
        out1_ready = 1'b0;
        drive(1, 1, 4'd1);
        tick();
        drive(1, 1, 4'd8);
        tick();
        out1_ready = 1'b1;
        drive(1, 1, 4'd7);
        check("fp_rdy_full", in_ready, 0);
        check("fp_d1_1", out1_data, 1);
        tick();
        check("fp_rdy_after", in_ready, 1);
        check("fp_d1_8", out1_data, 8);
        tick();
        check("fp_d1_7", out1_data, 7);
        check("fp_cnt1_a", cnt1, 5);
        drive(0, 0, 4'd0);
        tick();
        check("fp_v1_done", out1_valid, 0);
        check("fp_cnt1", cnt1, 6);

        // Counter wrap: 252 more words brings cnt0 from 4 to 256 -> 0
        for (int i = 0; i < 252; i++) begin
            drive(1, 0, 4'(i));
            tick();
            check("wr_d0", out0_data, 32'(i & 15));
        end
        drive(0, 0, 4'd0);
        tick();
        check("wr_cnt0", cnt0, 0);
        check("wr_cnt1", cnt1, 6);

        // Asynchronous reset with both FIFOs occupied
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1, 0, 4'd9);
        tick();
        drive(1, 1, 4'd10);
        tick();
        drive(0, 0, 4'd0);
        check("ar_v0_pre", out0_valid, 1);
        check("ar_v1_pre", out1_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_v0", out0_valid, 0);
        check("ar_v1", out1_valid, 0);
        check("ar_d0", out0_data, 0);
        check("ar_d1", out1_data, 0);
        check("ar_cnt1", cnt1, 0);
        check("ar_rdy", in_ready, 0);
        tick();
        @(negedge clk);
        rst_n      = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_stale_v0", out0_valid, 0);
            check("ar_stale_v1", out1_valid, 0);
        end
        check("ar_cnt0_post", cnt0, 0);
        check("ar_cnt1_post", cnt1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
